// File: rtl/arb8_rr.sv
// arb8_rr: 8-way round-robin arbiter holding each grant until done,
// with a watchdog that force-releases a grant held too long.
module arb8_rr #(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CW      = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] grant,
    output logic [2:0] sel,
    output logic       valid,
    output logic       timeout
);

    typedef enum logic {
        IDLE,
        BUSY
    } state_e;

    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_e        state_q, state_d;
    logic [2:0]    ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    grant_q, grant_d;
    logic [2:0]    sel_q, sel_d;
    logic          timeout_q, timeout_d;

    // Returns {found, index} of the first set bit scanning p, p+1, ... mod 8.
    function automatic logic [3:0] rr_pick(
        input logic [7:0] r,
        input logic [2:0] p
    );
        logic       found;
        logic [2:0] idx;
        logic [2:0] win;
        found = 1'b0;
        win   = 3'd0;
        for (int i = 0; i < 8; i++) begin
            idx = p + 3'(i);
            if (!found && r[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        return {found, win};
    endfunction

    logic [2:0] next_ptr;
    logic [3:0] pick_idle;
    logic [3:0] pick_rel;
    logic       wd_hit;

    always_comb begin
        next_ptr  = sel_q + 3'd1;
        pick_idle = rr_pick(req, ptr_q);
        pick_rel  = rr_pick(req, next_ptr);
        wd_hit    = (cnt_q == CNT_LAST);

        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        grant_d   = grant_q;
        sel_d     = sel_q;
        timeout_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (pick_idle[3]) begin
                    grant_d = 8'b1 << pick_idle[2:0];
                    sel_d   = pick_idle[2:0];
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                cnt_d = cnt_q + 1'b1;
                if (done || wd_hit) begin
                    // done wins over a coincident watchdog expiry
                    timeout_d = ~done;
                    ptr_d     = next_ptr;
                    cnt_d     = '0;
                    if (pick_rel[3]) begin
                        grant_d = 8'b1 << pick_rel[2:0];
                        sel_d   = pick_rel[2:0];
                    end else begin
                        grant_d = 8'h00;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 8'h00;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= 3'd0;
            cnt_q     <= '0;
            grant_q   <= 8'h00;
            sel_q     <= 3'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            grant_q   <= grant_d;
            sel_q     <= sel_d;
            timeout_q <= timeout_d;
        end
    end

    assign grant   = grant_q;
    assign sel     = sel_q;
    assign valid   = |grant_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_arb8_rr.sv
// tb_arb8_rr: directed scoreboard bench for arb8_rr with a short
// watchdog so forced releases are reachable quickly.
module tb_arb8_rr;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic [7:0] grant;
    logic [2:0] sel;
    logic       valid;
    logic       timeout;

    int n_cmp;
    int n_bad;

    typedef struct {
        string      tag;
        logic [7:0] grant;
        logic [2:0] sel;
        logic       valid;
        logic       timeout;
    } exp_t;

    exp_t sb_q[$];

    arb8_rr #(
        .TIMEOUT(4),
        .CW     (16)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .done   (done),
        .grant  (grant),
        .sel    (sel),
        .valid  (valid),
        .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, queue the outputs expected after the
    // next edge, then pop and compare once the edge has passed.
    task automatic step(input string tag, input logic r,
                        input logic [7:0] rq, input logic d,
                        input logic [7:0] eg, input logic [2:0] es,
                        input logic ev, input logic et);
        exp_t e;
        @(negedge clk);
        rst  = r;
        req  = rq;
        done = d;
        e.tag     = tag;
        e.grant   = eg;
        e.sel     = es;
        e.valid   = ev;
        e.timeout = et;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check({e.tag, ".grant"}, 32'(grant), 32'(e.grant));
        check({e.tag, ".sel"}, 32'(sel), 32'(e.sel));
        check({e.tag, ".valid"}, 32'(valid), 32'(e.valid));
        check({e.tag, ".timeout"}, 32'(timeout), 32'(e.timeout));
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        req   = 8'h00;
        done  = 1'b0;

        step("rst0", 1, 8'h00, 0, 8'h00, 3'd0, 0, 0);
        step("rst1", 1, 8'h00, 0, 8'h00, 3'd0, 0, 0);
        step("single", 0, 8'h04, 0, 8'h04, 3'd2, 1, 0);
        step("rel_idle", 0, 8'h00, 1, 8'h00, 3'd2, 0, 0);
        // ptr is now 3, so requester 3 beats requester 2
        step("ptr3", 0, 8'h0C, 0, 8'h08, 3'd3, 1, 0);
        step("hold1", 0, 8'h00, 0, 8'h08, 3'd3, 1, 0);
        step("hold2", 0, 8'h00, 0, 8'h08, 3'd3, 1, 0);
        step("hold3", 0, 8'h00, 0, 8'h08, 3'd3, 1, 0);
        step("wd_idle", 0, 8'h00, 0, 8'h00, 3'd3, 0, 1);
        step("wd_pulse", 0, 8'h00, 0, 8'h00, 3'd3, 0, 0);
        step("idle_done", 0, 8'h00, 1, 8'h00, 3'd3, 0, 0);

        step("rst_rr", 1, 8'hFF, 0, 8'h00, 3'd0, 0, 0);
        step("rr_first", 0, 8'hFF, 0, 8'h01, 3'd0, 1, 0);
        for (int i = 1; i <= 8; i++) begin
            step($sformatf("rr_done%0d", i), 0, 8'hFF, 1,
                 8'h01 << (i % 8), 3'(i % 8), 1, 0);
            step($sformatf("rr_hold%0d", i), 0, 8'hFF, 0,
                 8'h01 << (i % 8), 3'(i % 8), 1, 0);
        end

        step("to5", 0, 8'h20, 1, 8'h20, 3'd5, 1, 0);
        step("wrap0", 0, 8'h21, 1, 8'h01, 3'd0, 1, 0);
        step("back5", 0, 8'h20, 1, 8'h20, 3'd5, 1, 0);
        step("sole5", 0, 8'h20, 1, 8'h20, 3'd5, 1, 0);

        step("wd_c1", 0, 8'h11, 1, 8'h01, 3'd0, 1, 0);
        step("wd_c2", 0, 8'h11, 0, 8'h01, 3'd0, 1, 0);
        step("wd_c3", 0, 8'h11, 0, 8'h01, 3'd0, 1, 0);
        step("wd_c4", 0, 8'h11, 0, 8'h01, 3'd0, 1, 0);
        step("wd_fire", 0, 8'h11, 0, 8'h10, 3'd4, 1, 1);
        step("wd_c2b", 0, 8'h11, 0, 8'h10, 3'd4, 1, 0);
        step("wd_c3b", 0, 8'h11, 0, 8'h10, 3'd4, 1, 0);
        step("wd_c4b", 0, 8'h11, 0, 8'h10, 3'd4, 1, 0);
        step("done_vs_wd", 0, 8'h11, 1, 8'h01, 3'd0, 1, 0);

        step("to6", 0, 8'hC0, 1, 8'h40, 3'd6, 1, 0);
        step("mid_rst", 1, 8'hC0, 0, 8'h00, 3'd0, 0, 0);
        step("post_rst", 0, 8'hC0, 0, 8'h40, 3'd6, 1, 0);
        step("next7", 0, 8'hC0, 1, 8'h80, 3'd7, 1, 0);

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
